// File: rtl/logic_eval_pipe.sv
// ---------------------------------------------------------------------------
// logic_eval_pipe
//
// Two-stage valid/ready pipeline that evaluates a selectable three-input
// boolean function independently on each of WIDTH bit lanes and reports the
// population count of the result alongside it.
//
//   Stage S1 : captures operands a, b, c and the function select (mode).
//   Stage S2 : holds the per-lane result f and its popcount (ones).
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous reset, active low
//   in_valid   in   upstream offers a/b/c/mode
//   in_ready   out  offer is accepted this cycle
//   a, b, c    in   WIDTH-bit operands, lane i uses bit i of each
//   mode       in   0: a|(b&c)  1: a&(b|c)  2: majority  3: a^b^c
//   out_valid  out  f/ones hold a result
//   out_ready  in   downstream accepts the result this cycle
//   f          out  WIDTH-bit per-lane result
//   ones       out  number of 1 bits in f
//   res_cnt    out  CW-bit wrapping count of results taken downstream
// ---------------------------------------------------------------------------
module logic_eval_pipe #(
  parameter int WIDTH = 8,
  parameter int CW    = 16,
  localparam int OW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [OW-1:0]    ones,
  output logic [CW-1:0]    res_cnt
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic [1:0]       s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [OW-1:0]    ones_q, ones_d;

  logic [CW-1:0]    res_cnt_q, res_cnt_d;

  // -------------------------------------------------------------------------
  // Flow control. A stage may load when it is empty or when the stage ahead
  // of it is moving, so in_ready depends only on the two valid flags and
  // out_ready -- never on in_valid.
  // -------------------------------------------------------------------------
  logic s2_adv;
  logic s1_adv;
  logic out_xfer;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign out_xfer = s2_valid_q & out_ready;

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign f         = f_q;
  assign ones      = ones_q;
  assign res_cnt   = res_cnt_q;

  // -------------------------------------------------------------------------
  // Per-lane function evaluation from the S1 operands
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    logic la, lb, lc;
    logic f_or_and;
    logic f_and_or;
    logic f_maj;
    logic f_xor;

    assign la = s1_a_q[gi];
    assign lb = s1_b_q[gi];
    assign lc = s1_c_q[gi];

    assign f_or_and = la | (lb & lc);
    assign f_and_or = la & (lb | lc);
    assign f_maj    = (la & lb) | (la & lc) | (lb & lc);
    assign f_xor    = la ^ lb ^ lc;

    always_comb begin
      f_d[gi] = 1'b0;
      unique case (s1_mode_q)
        2'd0:    f_d[gi] = f_or_and;
        2'd1:    f_d[gi] = f_and_or;
        2'd2:    f_d[gi] = f_maj;
        default: f_d[gi] = f_xor;
      endcase
    end
  end

  // Popcount of the freshly computed result; registered with f so the two
  // outputs always describe the same transfer.
  always_comb begin
    ones_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_d = ones_d + OW'(f_d[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state selection
  // -------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_mode_d  = s1_mode_q;
    if (s1_adv) begin
      // Operands are loaded even without in_valid so S1 data is always a
      // defined value; only s1_valid decides whether it is a real entry.
      s1_valid_d = in_valid;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_c_d     = c;
      s1_mode_d  = mode;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
  end

  always_comb begin
    res_cnt_d = res_cnt_q;
    if (out_xfer) begin
      res_cnt_d = res_cnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      f_q        <= '0;
      ones_q     <= '0;
      res_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      if (s2_adv) begin
        f_q    <= f_d;
        ones_q <= ones_d;
      end
      res_cnt_q <= res_cnt_d;
    end
  end

endmodule

// File: tb/tb_logic_eval_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_eval_pipe
//
// Directed and random stimulus for logic_eval_pipe (WIDTH=8, CW=4), checked
// against a transaction-level model: an ordered queue of expected results,
// each tagged with the edge on which it was accepted.
// ---------------------------------------------------------------------------
module tb_logic_eval_pipe;

  localparam int W   = 8;
  localparam int CWT = 4;
  localparam int OWT = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b, c;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   f;
  logic [OWT-1:0] ones;
  logic [CWT-1:0] res_cnt;

  always #5 clk = ~clk;

  logic_eval_pipe #(.WIDTH(W), .CW(CWT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .ones     (ones),
    .res_cnt  (res_cnt)
  );

  typedef struct {
    logic [W-1:0] f;
    int           ones;
    int           acc;
  } ent_t;

  ent_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Lane-by-lane evaluation from vote counts.
  function automatic logic [W-1:0] ref_f(input int m, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic [W-1:0] z);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      int votes;
      votes = int'(x[i]) + int'(y[i]) + int'(z[i]);
      case (m)
        0:       r[i] = (x[i] == 1'b1) || (votes - int'(x[i]) == 2);
        1:       r[i] = (x[i] == 1'b1) && (votes >= 2);
        2:       r[i] = (votes >= 2);
        default: r[i] = (votes % 2 == 1);
      endcase
    end
    return r;
  endfunction

  // The oldest entry is visible at the output once at least one edge has
  // passed since it was accepted.
  function automatic bit head_valid();
    return (q.size() > 0) && (cyc - q[0].acc >= 1);
  endfunction

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input logic iv, input logic [1:0] m, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] z, input logic ordy);
    bit   exp_rdy, acc, pop, hv;
    ent_t e;
    in_valid  = iv;
    mode      = m;
    a         = x;
    b         = y;
    c         = z;
    out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = iv && exp_rdy;
    pop = head_valid() && ordy;
    @(posedge clk);
    cyc++;
    if (pop) begin
      e = q.pop_front();
      exp_cnt = (exp_cnt + 1) % (1 << CWT);
      $display("t=%0t out f=%02h ones=%0d", $time, e.f, e.ones);
    end
    if (acc) begin
      e.f    = ref_f(int'(m), x, y, z);
      e.ones = $countones(e.f);
      e.acc  = cyc;
      q.push_back(e);
      $display("t=%0t in  mode=%0d a=%02h b=%02h c=%02h", $time, m, x, y, z);
    end
    @(negedge clk);
    hv = head_valid();
    check("out_valid", {31'd0, out_valid}, {31'd0, hv});
    if (hv) begin
      check("f", {24'd0, f}, {24'd0, q[0].f});
      check("ones", {28'd0, ones}, q[0].ones);
    end
    check("res_cnt", {28'd0, res_cnt}, exp_cnt);
  endtask

  // Reset for one edge while a transfer is offered and downstream is ready.
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = W'($urandom);
    b         = W'($urandom);
    c         = W'($urandom);
    mode      = 2'($urandom);
    out_ready = 1'b1;
    @(posedge clk);
    cyc++;
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res_cnt", {28'd0, res_cnt}, 32'd0);
    $display("t=%0t reset", $time);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] tbl_f [4];
  int           tbl_o [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; mode = '0;
    tbl_f = '{8'hEA, 8'hA8, 8'hE8, 8'h96};
    tbl_o = '{5, 3, 4, 4};
    @(negedge clk);
    do_reset();

    // Basic example: result two edges after presentation, count one later.
    step(1'b1, 2'd0, 8'h0F, 8'hF0, 8'hFF, 1'b1);
    step(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("ex_f", {24'd0, f}, 32'hFF);
    check("ex_ones", {28'd0, ones}, 32'd8);
    check("ex_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("ex_cnt", {28'd0, res_cnt}, 32'd1);

    // Back-to-back stream of all four modes, no gaps.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'(k), 8'hAA, 8'hCC, 8'hF0, 1'b1);
      if (k > 0) begin
        check("stream_f", {24'd0, f}, {24'd0, tbl_f[k-1]});
        check("stream_ones", {28'd0, ones}, tbl_o[k-1]);
      end
    end
    step(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("stream_f_last", {24'd0, f}, {24'd0, tbl_f[3]});
    step(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: three offers, two taken; third taken once out_ready rises.
    step(1'b1, 2'd2, 8'h12, 8'h34, 8'h56, 1'b0);
    step(1'b1, 2'd3, 8'h9A, 8'hBC, 8'hDE, 1'b0);
    step(1'b1, 2'd1, 8'hF0, 8'h0F, 8'h3C, 1'b0);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 2'd1, 8'hF0, 8'h0F, 8'h3C, 1'b0);
    // Full pipe with simultaneous in and out transfer.
    step(1'b1, 2'd1, 8'hF0, 8'h0F, 8'h3C, 1'b1);
    step(1'b1, 2'd0, 8'h55, 8'h66, 8'h77, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);

    // Counter wrap with CW=4: 17 results leave, count ends at 1.
    do_reset();
    for (int k = 0; k < 17; k++) step(1'b1, 2'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("wrap_cnt", {28'd0, res_cnt}, 32'd1);

    // Reset with two entries buffered, then a fresh transfer.
    step(1'b1, 2'd3, 8'h11, 8'h22, 8'h44, 1'b0);
    step(1'b1, 2'd2, 8'h81, 8'h42, 8'h24, 1'b0);
    do_reset();
    step(1'b1, 2'd1, 8'hC3, 8'h3C, 8'hFF, 1'b1);
    step(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("post_rst_f", {24'd0, f}, 32'hC3);

    // Random traffic with one reset part-way through.
    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset();
      step(($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom), W'($urandom),
           W'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
